// File: rtl/jpeg_marker_segmenter.sv
// JPEG marker segmenter: splits a JPEG byte stream into DQT/SOF0/DHT/SOS payloads
// and de-stuffed entropy-coded data, presented through one registered output stage.
module jpeg_marker_segmenter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             seg_valid,
    input  logic             seg_ready,
    output logic [7:0]       seg_byte,
    output logic [2:0]       seg_type,
    output logic             seg_first,
    output logic             seg_last,
    output logic [LEN_W-1:0] seg_len,
    output logic             rst_marker,
    output logic             frame_done,
    output logic             err,
    output logic [1:0]       err_code
);
    typedef enum logic [3:0] {
        SOI_FF, SOI_D8, MARK_FF, MARK_CODE, LEN_HI, LEN_LO,
        PAYLOAD, SKIP, ECS, ECS_FF, ERR
    } state_t;

    localparam logic [2:0] T_SOS = 3'd3;
    localparam logic [2:0] T_ECS = 3'd4;

    state_t           state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic             skip_q, skip_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             ecs_first_q, ecs_first_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_byte_q, pend_byte_d;
    logic             seg_valid_q, seg_valid_d;
    logic [7:0]       seg_byte_q, seg_byte_d;
    logic [2:0]       seg_type_q, seg_type_d;
    logic             seg_first_q, seg_first_d;
    logic             seg_last_q, seg_last_d;
    logic [LEN_W-1:0] seg_len_q, seg_len_d;
    logic             rst_marker_q, rst_marker_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    state_t     mk_next;
    logic [2:0] mk_type;
    logic       mk_skip, mk_bad, mk_eoi;

    logic             acc, out_free, emitting_state;
    logic             emit, emit_first, emit_last, ecs_data, do_mark;
    logic [7:0]       emit_byte, ecs_byte;
    logic [2:0]       emit_type;
    logic [LEN_W-1:0] emit_len;
    logic [15:0]      len16;

    assign len16          = {len_hi_q, in_byte};
    assign out_free       = !seg_valid_q || seg_ready;
    assign emitting_state = state_q inside {PAYLOAD, ECS, ECS_FF};
    assign in_ready       = emitting_state ? out_free : 1'b1;
    assign acc            = in_valid && in_ready;

    // Marker code decode, shared by MARK_CODE and the ECS-terminating path.
    always_comb begin
        mk_next = LEN_HI;
        mk_type = 3'd0;
        mk_skip = 1'b1;
        mk_bad  = 1'b0;
        mk_eoi  = 1'b0;
        case (in_byte)
            8'hFF: mk_next = MARK_CODE;
            8'hD9: begin mk_eoi = 1'b1; mk_next = SOI_FF; end
            8'hDB: begin mk_type = 3'd0; mk_skip = 1'b0; end
            8'hC0: begin mk_type = 3'd1; mk_skip = 1'b0; end
            8'hC4: begin mk_type = 3'd2; mk_skip = 1'b0; end
            8'hDA: begin mk_type = 3'd3; mk_skip = 1'b0; end
            default: mk_bad = (in_byte == 8'h00) || (in_byte == 8'hD8) ||
                              (in_byte[7:3] == 5'b11010) ||
                              (in_byte[7:4] == 4'hC && in_byte != 8'hC8 && in_byte != 8'hCC);
        endcase
        if (mk_bad) mk_next = ERR;
    end

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        skip_d       = skip_q;
        len_hi_d     = len_hi_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        first_d      = first_q;
        ecs_first_d  = ecs_first_q;
        pend_vld_d   = pend_vld_q;
        pend_byte_d  = pend_byte_q;
        seg_valid_d  = seg_valid_q && !seg_ready;
        seg_byte_d   = seg_byte_q;
        seg_type_d   = seg_type_q;
        seg_first_d  = seg_first_q;
        seg_last_d   = seg_last_q;
        seg_len_d    = seg_len_q;
        rst_marker_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        err_code_d   = err_code_q;
        emit         = 1'b0;
        emit_byte    = in_byte;
        emit_type    = type_q;
        emit_first   = first_q;
        emit_last    = 1'b0;
        emit_len     = len_q;
        ecs_data     = 1'b0;
        ecs_byte     = in_byte;
        do_mark      = 1'b0;
        if (acc) begin
            case (state_q)
                SOI_FF: if (in_byte == 8'hFF) state_d = SOI_D8;
                        else begin state_d = ERR; err_code_d = 2'd1; end
                SOI_D8: if (in_byte == 8'hD8) state_d = MARK_FF;
                        else begin state_d = ERR; err_code_d = 2'd1; end
                MARK_FF: if (in_byte == 8'hFF) state_d = MARK_CODE;
                         else begin state_d = ERR; err_code_d = 2'd2; end
                MARK_CODE: do_mark = 1'b1;
                LEN_HI: begin
                    len_hi_d = in_byte;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    len_d   = LEN_W'(len16 - 16'd2);
                    cnt_d   = LEN_W'(len16 - 16'd2);
                    first_d = 1'b1;
                    if (len16 < 16'd2) begin
                        state_d    = ERR;
                        err_code_d = 2'd3;
                    end else if (len16 == 16'd2) begin
                        if (!skip_q && type_q == T_SOS) begin
                            state_d     = ECS;
                            ecs_first_d = 1'b1;
                        end else begin
                            state_d = MARK_FF;
                        end
                    end else begin
                        state_d = skip_q ? SKIP : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    emit      = 1'b1;
                    emit_last = (cnt_q == LEN_W'(1));
                    first_d   = 1'b0;
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        if (type_q == T_SOS) begin
                            state_d     = ECS;
                            ecs_first_d = 1'b1;
                        end else begin
                            state_d = MARK_FF;
                        end
                    end
                end
                SKIP: begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = MARK_FF;
                end
                ECS: if (in_byte == 8'hFF) state_d = ECS_FF;
                     else ecs_data = 1'b1;
                ECS_FF: begin
                    if (in_byte == 8'h00) begin
                        ecs_data = 1'b1;
                        ecs_byte = 8'hFF;
                        state_d  = ECS;
                    end else if (in_byte == 8'hFF) begin
                        state_d = ECS_FF;
                    end else if (in_byte[7:3] == 5'b11010) begin
                        rst_marker_d = 1'b1;
                        state_d      = ECS;
                    end else begin
                        // Terminating marker: flush the held byte as the segment's last.
                        if (pend_vld_q) begin
                            emit       = 1'b1;
                            emit_byte  = pend_byte_q;
                            emit_type  = T_ECS;
                            emit_first = ecs_first_q;
                            emit_last  = 1'b1;
                            emit_len   = '0;
                            pend_vld_d = 1'b0;
                        end
                        do_mark = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (do_mark) begin
            state_d      = mk_next;
            type_d       = mk_type;
            skip_d       = mk_skip;
            frame_done_d = mk_eoi;
            if (mk_bad) err_code_d = 2'd2;
        end
        if (ecs_data) begin
            if (pend_vld_q) begin
                emit        = 1'b1;
                emit_byte   = pend_byte_q;
                emit_type   = T_ECS;
                emit_first  = ecs_first_q;
                emit_last   = 1'b0;
                emit_len    = '0;
                ecs_first_d = 1'b0;
            end
            pend_byte_d = ecs_byte;
            pend_vld_d  = 1'b1;
        end
        if (emit) begin
            seg_valid_d = 1'b1;
            seg_byte_d  = emit_byte;
            seg_type_d  = emit_type;
            seg_first_d = emit_first;
            seg_last_d  = emit_last;
            seg_len_d   = emit_len;
        end
        if (state_d == ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SOI_FF;
            type_q       <= '0;
            skip_q       <= 1'b0;
            cnt_q        <= '0;
            len_q        <= '0;
            first_q      <= 1'b0;
            ecs_first_q  <= 1'b0;
            pend_vld_q   <= 1'b0;
            seg_valid_q  <= 1'b0;
            seg_type_q   <= '0;
            seg_first_q  <= 1'b0;
            seg_last_q   <= 1'b0;
            seg_len_q    <= '0;
            rst_marker_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            skip_q       <= skip_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            first_q      <= first_d;
            ecs_first_q  <= ecs_first_d;
            pend_vld_q   <= pend_vld_d;
            seg_valid_q  <= seg_valid_d;
            seg_type_q   <= seg_type_d;
            seg_first_q  <= seg_first_d;
            seg_last_q   <= seg_last_d;
            seg_len_q    <= seg_len_d;
            rst_marker_q <= rst_marker_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // Pure data registers; their contents are qualified by the valid flags above.
    always_ff @(posedge clk) begin
        len_hi_q    <= len_hi_d;
        pend_byte_q <= pend_byte_d;
        seg_byte_q  <= seg_byte_d;
    end

    assign seg_valid  = seg_valid_q;
    assign seg_byte   = seg_byte_q;
    assign seg_type   = seg_type_q;
    assign seg_first  = seg_first_q;
    assign seg_last   = seg_last_q;
    assign seg_len    = seg_len_q;
    assign rst_marker = rst_marker_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_jpeg_marker_segmenter.sv
// Directed bench for jpeg_marker_segmenter with an expected-output queue.
module tb_jpeg_marker_segmenter;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             in_ready;
    logic             seg_valid;
    logic             seg_ready = 1'b1;
    logic [7:0]       seg_byte;
    logic [2:0]       seg_type;
    logic             seg_first;
    logic             seg_last;
    logic [LEN_W-1:0] seg_len;
    logic             rst_marker;
    logic             frame_done;
    logic             err;
    logic [1:0]       err_code;

    typedef struct packed {
        logic [7:0]       b;
        logic [2:0]       t;
        logic             f;
        logic             l;
        logic [LEN_W-1:0] n;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] stim[$];
    logic [7:0] pay[$];
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int rm_cnt = 0;
    int fd_base, rm_base;

    jpeg_marker_segmenter #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_byte(seg_byte), .seg_type(seg_type), .seg_first(seg_first),
        .seg_last(seg_last), .seg_len(seg_len), .rst_marker(rst_marker),
        .frame_done(frame_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_cnt++;
            if (rst_marker) rm_cnt++;
            if (seg_valid && seg_ready) begin
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_beat", 32'({seg_byte, seg_type, seg_first, seg_last, seg_len}),
                          32'(mon_e));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        forever begin
            @(negedge clk);
            if (in_ready || n > 200) break;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stim();
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i]);
    endtask

    task automatic push_pay(input logic [2:0] t, input int len);
        exp_t e;
        for (int i = 0; i < pay.size(); i++) begin
            e.b = pay[i];
            e.t = t;
            e.f = (i == 0);
            e.l = (i == pay.size() - 1);
            e.n = LEN_W'(len);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_one(input logic [7:0] b, input logic [2:0] t, input logic f,
                            input logic l, input int len);
        exp_t e;
        e.b = b; e.t = t; e.f = f; e.l = l; e.n = LEN_W'(len);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || seg_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg_valid", 32'(seg_valid), 32'd0);
        check("rst_first_last", 32'({seg_first, seg_last}), 32'd0);
        check("rst_pulses", 32'({rst_marker, frame_done}), 32'd0);
        check("rst_err", 32'({err, err_code}), 32'd0);
        check("rst_seg_len", 32'(seg_len), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // SOF0 frame
        fd_base = fd_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h0B, 8'h08, 8'h00, 8'h10,
                 8'h00, 8'h10, 8'h01, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hD9};
        pay  = '{8'h08, 8'h00, 8'h10, 8'h00, 8'h10, 8'h01, 8'h01, 8'h11, 8'h00};
        push_pay(3'd1, 9);
        send_stim();
        drain();
        check("sof_frame_done", 32'(fd_cnt - fd_base), 32'd1);
        check("sof_err", 32'(err), 32'd0);

        // APP0 skipped, one-byte DQT, second frame without reset
        fd_base = fd_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00, 8'h04, 8'hAA, 8'hBB,
                 8'hFF, 8'hDB, 8'h00, 8'h03, 8'h07, 8'hFF, 8'hD9};
        push_one(8'h07, 3'd0, 1'b1, 1'b1, 1);
        send_stim();
        drain();
        check("dqt_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // SOS + ECS with stuffing, restart marker and fill
        fd_base = fd_cnt;
        rm_base = rm_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h03, 8'h01, 8'h12, 8'hFF, 8'h00,
                 8'h34, 8'hFF, 8'hD0, 8'h56, 8'hFF, 8'hFF, 8'hD9};
        push_one(8'h01, 3'd3, 1'b1, 1'b1, 1);
        push_one(8'h12, 3'd4, 1'b1, 1'b0, 0);
        push_one(8'hFF, 3'd4, 1'b0, 1'b0, 0);
        push_one(8'h34, 3'd4, 1'b0, 1'b0, 0);
        push_one(8'h56, 3'd4, 1'b0, 1'b1, 0);
        send_stim();
        drain();
        check("ecs_rst_marker", 32'(rm_cnt - rm_base), 32'd1);
        check("ecs_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // Length-2 DQT and empty SOS/ECS emit nothing
        fd_base = fd_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h02, 8'hFF, 8'hDA, 8'h00, 8'h02,
                 8'hFF, 8'hD9};
        send_stim();
        drain();
        check("empty_frame_done", 32'(fd_cnt - fd_base), 32'd1);
        check("empty_err", 32'(err), 32'd0);

        // DHT with downstream stall
        fd_base = fd_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC4, 8'h00, 8'h0A, 8'hA0, 8'hA1, 8'hA2};
        pay  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        push_pay(3'd2, 8);
        send_stim();
        seg_ready = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'hA3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_hold", 32'({seg_valid, seg_byte}), 32'h1A2);
        end
        @(posedge clk);
        #1;
        seg_ready = 1'b1;
        stim = '{8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hFF, 8'hD9};
        send_stim();
        drain();
        check("dht_frame_done", 32'(fd_cnt - fd_base), 32'd1);

        // Error cases, each followed by input that must be drained silently
        do_reset();
        stim = '{8'h00, 8'hD8};
        send_stim();
        check("err_soi", 32'({err, err_code}), 32'h5);
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h03, 8'h07};
        send_stim();
        drain();
        check("err_soi_sticky", 32'({err, err_code}), 32'h5);

        do_reset();
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC2, 8'h00, 8'h03, 8'h07};
        send_stim();
        drain();
        check("err_marker", 32'({err, err_code}), 32'h6);

        do_reset();
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h01, 8'h07, 8'hFF};
        send_stim();
        drain();
        check("err_len", 32'({err, err_code}), 32'h7);

        // Reset mid-SOF payload with a byte still held in the output register
        do_reset();
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h0B, 8'h08, 8'h00, 8'h10};
        pay  = '{8'h08, 8'h00, 8'h10};
        exp_q.delete();
        push_one(8'h08, 3'd1, 1'b1, 1'b0, 9);
        push_one(8'h00, 3'd1, 1'b0, 1'b0, 9);
        push_one(8'h10, 3'd1, 1'b0, 1'b0, 9);
        send_stim();
        drain();
        seg_ready = 1'b0;
        send_byte(8'h00);
        do_reset();
        seg_ready = 1'b1;
        fd_base = fd_cnt;
        stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h0B, 8'h08, 8'h00, 8'h10,
                 8'h00, 8'h10, 8'h01, 8'h01, 8'h11, 8'h00, 8'hFF, 8'hD9};
        pay  = '{8'h08, 8'h00, 8'h10, 8'h00, 8'h10, 8'h01, 8'h01, 8'h11, 8'h00};
        push_pay(3'd1, 9);
        send_stim();
        drain();
        check("rerun_frame_done", 32'(fd_cnt - fd_base), 32'd1);
        check("rerun_err", 32'({err, err_code}), 32'd0);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
